// File: rtl/fwd_track_if.sv
// Issue, forwarding and writeback bundle of the operand-forwarding tracker.
// master = issue/pipeline side, slave = fwd_track.
interface fwd_track_if #(
   parameter int DATA_W = 16,
   parameter int REG_AW = 3,
   parameter int NRD    = 2
);
   logic                   flush;
   logic                   iss_valid;
   logic                   iss_wr_en;
   logic [REG_AW-1:0]      iss_wr_num;
   logic                   iss_late;
   logic [DATA_W-1:0]      ex_data;
   logic [DATA_W-1:0]      mem_data;
   logic [NRD*REG_AW-1:0]  rd_num;
   logic [NRD*DATA_W-1:0]  rd_rf_data;
   logic [NRD*DATA_W-1:0]  rd_data;
   logic                   stall;
   logic                   wb_valid;
   logic [REG_AW-1:0]      wb_num;
   logic [DATA_W-1:0]      wb_data;

   modport master (
      output flush, iss_valid, iss_wr_en, iss_wr_num, iss_late,
      output ex_data, mem_data, rd_num, rd_rf_data,
      input  rd_data, stall, wb_valid, wb_num, wb_data
   );

   modport slave (
      input  flush, iss_valid, iss_wr_en, iss_wr_num, iss_late,
      input  ex_data, mem_data, rd_num, rd_rf_data,
      output rd_data, stall, wb_valid, wb_num, wb_data
   );
endinterface

// File: rtl/fwd_track.sv
// Operand-forwarding / load-use hazard tracker over the last DEPTH issued instructions.
// Optional macro KL_FWD_REG0_ZERO_EN: register 0 hardwired to zero.
module fwd_track #(
   parameter int DATA_W     = 16,
   parameter int REG_AW     = 3,
   parameter int DEPTH      = 4,
   parameter int LATE_STAGE = 2,
   parameter int NRD        = 2
) (
   input logic        clk,
   input logic        rst_n,
   fwd_track_if.slave bus
);
   // Handshake: the instruction on iss_* moves into E[1] at a rising edge when
   // iss_valid = 1 and stall = 0; while stall = 1 the issuer holds iss_* unchanged.

   logic [DEPTH:1]    e_valid, e_wr, e_late;
   logic [REG_AW-1:0] e_num  [1:DEPTH];
   logic [DATA_W-1:0] e_data [1:DEPTH];

   logic [DEPTH:1]    p_rdy;
   logic [DATA_W-1:0] p_val  [1:DEPTH];
   logic              stall_any;
   logic [NRD*DATA_W-1:0] rd_data_c;

   // Result visible from each stage: live at the production point, registered after it.
   always_comb begin
      for (int k = 1; k <= DEPTH; k++) begin
         p_rdy[k] = 1'b1;
         p_val[k] = e_data[k];
         if (e_late[k]) begin
            if (k < LATE_STAGE)       p_rdy[k] = 1'b0;
            else if (k == LATE_STAGE) p_val[k] = bus.mem_data;
         end else if (k == 1) begin
            p_val[k] = bus.ex_data;
         end
      end
   end

   always_comb begin : fwd_sel
      logic [REG_AW-1:0] rd_p;
      logic              hit, rdy;
      logic [DATA_W-1:0] val;
      stall_any = 1'b0;
      rd_data_c = '0;
      for (int p = 0; p < NRD; p++) begin
         rd_p = bus.rd_num[p*REG_AW +: REG_AW];
         hit  = 1'b0;
         rdy  = 1'b0;
         val  = '0;
         // Scan oldest to youngest so the youngest match overwrites.
         for (int k = DEPTH; k >= 1; k--) begin
`ifdef KL_FWD_REG0_ZERO_EN
            if (e_valid[k] && e_wr[k] && (e_num[k] == rd_p) && (rd_p != '0)) begin
`else
            if (e_valid[k] && e_wr[k] && (e_num[k] == rd_p)) begin
`endif
               hit = 1'b1;
               rdy = p_rdy[k];
               val = p_val[k];
            end
         end
         rd_data_c[p*DATA_W +: DATA_W] = (hit && rdy) ? val : bus.rd_rf_data[p*DATA_W +: DATA_W];
`ifdef KL_FWD_REG0_ZERO_EN
         if (rd_p == '0) rd_data_c[p*DATA_W +: DATA_W] = '0;
`endif
         if (bus.iss_valid && hit && !rdy) stall_any = 1'b1;
      end
   end

   assign bus.rd_data = rd_data_c;
   assign bus.stall   = stall_any;
`ifdef KL_FWD_REG0_ZERO_EN
   assign bus.wb_valid = e_valid[DEPTH] & e_wr[DEPTH] & (e_num[DEPTH] != '0);
`else
   assign bus.wb_valid = e_valid[DEPTH] & e_wr[DEPTH];
`endif
   assign bus.wb_num  = e_num[DEPTH];
   assign bus.wb_data = p_val[DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 1; k <= DEPTH; k++) begin
            e_valid[k] <= 1'b0;
            e_wr[k]    <= 1'b0;
            e_late[k]  <= 1'b0;
            e_num[k]   <= '0;
            e_data[k]  <= '0;
         end
      end else begin
         for (int k = DEPTH; k >= 2; k--) begin
            e_valid[k] <= e_valid[k-1] & ~bus.flush;
            e_wr[k]    <= e_wr[k-1];
            e_late[k]  <= e_late[k-1];
            e_num[k]   <= e_num[k-1];
            e_data[k]  <= p_rdy[k-1] ? p_val[k-1] : e_data[k-1];
         end
         // A stalled issue becomes a bubble; the issuer re-presents it next cycle.
         e_valid[1] <= bus.iss_valid & ~stall_any & ~bus.flush;
         e_wr[1]    <= bus.iss_valid & bus.iss_wr_en & ~stall_any;
         e_late[1]  <= bus.iss_late;
         e_num[1]   <= bus.iss_wr_num;
         e_data[1]  <= '0;
      end
   end
endmodule

// File: doc/fwd_track.md
# fwd_track

Parametrised operand-forwarding and hazard tracker for the Kaiserlake integer pipeline. It holds a shift pipeline of the last DEPTH issued instructions: their destination register, their write-enable and their result. For NRD read ports it selects the youngest in-flight result or the register-file value. It raises a stall when the youngest producer is a late-result instruction (load) whose data does not exist yet, and it emits the writeback of the oldest entry.

## Interface
Parameters:
- DATA_W, 16, datapath width
- REG_AW, 3, register number width
- DEPTH, 4, tracked in-flight stages E[1..DEPTH], must be ≥ 2
- LATE_STAGE, 2, stage at which a late result becomes available, 2 ≤ LATE_STAGE ≤ DEPTH
- NRD, 2, number of operand read ports

Ports:
- clk, in, 1, rising-edge clock
- rst_n, in, 1, asynchronous active-low reset
- flush, in, 1, synchronous kill of all tracked entries
- iss_valid, in, 1, instruction issuing this cycle
- iss_wr_en, in, 1, issuing instruction writes a register
- iss_wr_num, in, REG_AW, destination register
- iss_late, in, 1, result arrives at LATE_STAGE instead of stage 1
- ex_data, in, DATA_W, result of the instruction in E[1]
- mem_data, in, DATA_W, late result of the instruction in E[LATE_STAGE]
- rd_num, in, NRD*REG_AW, port p uses slice p
- rd_rf_data, in, NRD*DATA_W, register-file read data per port
- rd_data, out, NRD*DATA_W, forwarded operand per port
- stall, out, 1, hold the issuing instruction
- wb_valid, out, 1, E[DEPTH] writes back this cycle
- wb_num, out, REG_AW, writeback register
- wb_data, out, DATA_W, writeback data

## Operation
- Each entry holds: valid, wr, num, late, data. Each entry resets to all-zero.
- Entry result source:
  - E[1] non-late: ex_data, combinational.
  - E[LATE_STAGE] late: mem_data, combinational.
  - Stages after the production point: the registered data field.
  - Late entries in stages < LATE_STAGE: not ready.
- Match on port p at stage k: E[k].valid & E[k].wr & (E[k].num == rd_num[p]).
- Forwarding selects the lowest-k match (youngest). It never falls through to an older match.
- No match: rd_data[p] = rd_rf_data[p].
- The youngest match on port p is not ready: stall = 1.
  - rd_data[p] is then don't-care, but must be deterministic and driven by rd_rf_data[p].
- stall is the OR over all ports. A port is only considered when iss_valid = 1; with iss_valid = 0, stall = 0.
- Advance every cycle:
  - E[k+1] <= E[k].
  - data is updated with the production value if E[k] produces at stage k; otherwise it is kept.
- E[1] load:
  - Normal: E[1] <= {iss_valid, iss_valid & iss_wr_en, iss_wr_num, iss_late, 0}.
  - When stall = 1, E[1] <= bubble (valid = 0). The issue side re-presents the same instruction next cycle.
- Writeback: wb_valid = E[DEPTH].valid & E[DEPTH].wr; wb_num and wb_data come from E[DEPTH].
  - The register file commits at the end of that cycle.
  - The read of the same register in the same cycle is covered by forwarding from E[DEPTH].
- Flush has priority over issue and advance: all valid bits are cleared at the edge, and no writeback occurs the following cycle. wb_* outputs during the flush cycle itself still reflect E[DEPTH].

## Timing
- rd_data and stall: combinational from inputs and state, 0-cycle latency.
- Entries: registered, so one stage per cycle. An instruction issued at edge n is in E[k] during cycle n+k-1 and writes back in cycle n+DEPTH-1.
- Non-late producer followed by an immediate consumer: 0 stall cycles (forwarded from ex_data).
- Late producer followed by an immediate consumer: LATE_STAGE-1 stall cycles.
- Reset values: wb_valid = 0, wb_num = 0, wb_data = 0, stall = 0, and rd_data = rd_rf_data because no entries are valid.
- Reset mid-operation: all entries are dropped immediately (asynchronous) and no writeback occurs.
- If one register appears in multiple stages, only the youngest is visible. Older entries still write back in order, so the register file ends with the youngest value.

## Configuration
- KL_FWD_REG0_ZERO_EN
  - Defined: register 0 is hardwired to zero. Matches on num = 0 are suppressed, rd_data[p] = 0 when rd_num[p] = 0, wb_valid is forced to 0 for num = 0, and register 0 never causes a stall.
  - Undefined: register 0 is an ordinary register.

## Test plan
- Reset with rd_rf_data = {0x1111, 0x2222} -> rd_data = {0x1111, 0x2222}, stall = 0, wb_valid = 0.
- Back-to-back forwarding:
  - Issue non-late r3 with ex_data = 0xBEEF, then read r3 on port 0 the next cycle -> rd_data[0] = 0xBEEF, no stall.
  - After DEPTH cycles -> wb_valid = 1, wb_num = 3, wb_data = 0xBEEF.
- Youngest wins: issue r2 = 0x0001 then r2 = 0x0002, then read r2 -> 0x0002. Register-file writebacks occur in order 0x0001 then 0x0002.
- Load-use: late r5 followed by a read of r5 (LATE_STAGE = 2) -> stall = 1 for one cycle and a bubble enters E[1]. The next cycle rd_data = mem_data = 0xCAFE with stall = 0.
- Flush while r4 is in E[2..3] -> read r4 returns rd_rf_data and no wb_valid pulses. Asserting rst_n = 0 mid-stream gives the same result asynchronously.
- With KL_FWD_REG0_ZERO_EN: issue r0 = 0x7777, then read r0 -> rd_data = 0, stall = 0, wb_valid stays 0.
